// File: rtl/lcd_win_ctrl.sv
// Image-window LCD controller: serially loads an IMG_W x IMG_H frame, then streams
// a WIN x WIN window of it per command, with clamped shifts and a mirror readout mode.
//   state   | meaning
//   IDLE    | waiting for a command, busy low
//   LOAD    | shifting N frame pixels in from datain
//   UPD     | applying the window move / mirror toggle
//   OUT     | streaming M window pixels, then one closing cycle
module lcd_win_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N    = IMG_W * IMG_H;
    localparam int M    = WIN * WIN;
    localparam int XMAX = IMG_W - WIN;
    localparam int YMAX = IMG_H - WIN;
    localparam int X0   = (XMAX + 1) / 2;
    localparam int Y0   = (YMAX + 1) / 2;
    localparam int XW   = (XMAX > 0) ? $clog2(XMAX + 1) : 1;
    localparam int YW   = (YMAX > 0) ? $clog2(YMAX + 1) : 1;
    localparam int WW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int TW   = $clog2(((N > M) ? N : M + 1) + 1);

    localparam logic [2:0] CMD_LOAD   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_UP     = 3'd4;
    localparam logic [2:0] CMD_DOWN   = 3'd5;
    localparam logic [2:0] CMD_ORIGIN = 3'd6;
    localparam logic [2:0] CMD_MIRROR = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_UPD, ST_OUT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [WW-1:0]   r_q, r_d;
    logic [WW-1:0]   c_q, c_d;
    logic            mir_q, mir_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            vld_q, vld_d;
    logic            shift_en;
    logic [DW-1:0]   buf_q [N];
    logic [AW-1:0]   rd_addr;
    int              col_i;

    always_comb begin
        col_i   = mir_q ? (int'(x_q) + WIN - 1 - int'(c_q)) : (int'(x_q) + int'(c_q));
        rd_addr = AW'((int'(y_q) + int'(r_q)) * IMG_W + col_i);
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        tmr_d    = tmr_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        c_d      = c_q;
        mir_d    = mir_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd;
                    if (cmd == CMD_LOAD) begin
                        state_d = ST_LOAD;
                        tmr_d   = TW'(N - 1);
                    end else begin
                        state_d = ST_UPD;
                    end
                end
            end
            ST_LOAD: begin
                shift_en = 1'b1;
                if (tmr_q == '0) state_d = ST_UPD;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ST_UPD: begin
                case (cmd_q)
                    CMD_LOAD: begin
                        x_d = XW'(X0);
                        y_d = YW'(Y0);
                    end
                    CMD_RIGHT:  if (x_q != XW'(XMAX)) x_d = x_q + 1'b1;
                    CMD_LEFT:   if (x_q != '0)        x_d = x_q - 1'b1;
                    CMD_UP:     if (y_q != '0)        y_d = y_q - 1'b1;
                    CMD_DOWN:   if (y_q != YW'(YMAX)) y_d = y_q + 1'b1;
                    CMD_ORIGIN: begin
                        x_d = '0;
                        y_d = '0;
                    end
                    CMD_MIRROR: mir_d = ~mir_q;
                    default: ;
                endcase
                r_d     = '0;
                c_d     = '0;
                tmr_d   = TW'(M);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                // tmr counts M..1 for pixels; the terminal count closes the phase
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    vld_d  = 1'b1;
                    dout_d = buf_q[rd_addr];
                    tmr_d  = tmr_q - 1'b1;
                    if (c_q == WW'(WIN - 1)) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            tmr_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            mir_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tmr_q   <= tmr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            c_q     <= c_d;
            mir_q   <= mir_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    // Raster-order shift-in: after N shifts the first pixel sits at index 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N; j++) buf_q[j] <= '0;
        end else if (shift_en) begin
            for (int j = 0; j < N - 1; j++) buf_q[j] <= buf_q[j + 1];
            buf_q[N - 1] <= datain;
        end
    end

    assign dataout      = dout_q;
    assign output_valid = vld_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed-vector bench for lcd_win_ctrl: a command table with hand-computed window
// streams, plus hand sequences for ignored commands and reset mid-output.
module tb_lcd_win_ctrl;

    localparam int DW = 8;
    localparam int N  = 36;
    localparam int M  = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] datain = '0;
    logic [2:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    int n_cmp = 0;
    int n_fail = 0;

    lcd_win_ctrl #(.DW(DW), .IMG_W(6), .IMG_H(6), .WIN(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      cmd;
        logic [M*DW-1:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Issues one command and checks busy/valid every cycle plus each window pixel.
    // With hold set, cmd_valid stays high with cmd=2 for the whole busy period.
    task automatic run_cmd(input logic [2:0] c, input logic [M*DW-1:0] exp, input bit hold);
        int pre;
        int pix;
        pre = (c == 3'd1) ? N : 0;
        pix = 0;
        check("idle_before_cmd", {31'd0, busy}, 32'd0);
        cmd       = c;
        cmd_valid = 1'b1;
        datain    = '0;
        @(negedge clk);
        cmd_valid = hold;
        if (hold) cmd = 3'd2;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        for (int j = 1; j <= pre + M + 2; j++) begin
            datain = DW'(j - 1);
            @(negedge clk);
            check("valid", {31'd0, output_valid},
                  {31'd0, (j >= pre + 2) && (j < pre + 2 + M)});
            check("busy", {31'd0, busy}, {31'd0, j < pre + M + 2});
            if ((j >= pre + 2) && (j < pre + 2 + M)) begin
                check("pixel", {24'd0, dataout}, {24'd0, exp[(M-1-pix)*DW +: DW]});
                pix++;
            end
        end
        cmd_valid = 1'b0;
        if (hold) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("no_extra_cmd", {31'd0, busy}, 32'd0);
            end
        end
        check("dataout_hold", {24'd0, dataout}, {24'd0, exp[DW-1:0]});
    endtask

    initial begin
        logic [M*DW-1:0] w_org, w_last;
        w_org  = {8'd0, 8'd1, 8'd2, 8'd6, 8'd7, 8'd8, 8'd12, 8'd13, 8'd14};
        w_last = {8'd7, 8'd8, 8'd9, 8'd13, 8'd14, 8'd15, 8'd19, 8'd20, 8'd21};
        vecs[0]  = '{3'd1, {8'd14, 8'd15, 8'd16, 8'd20, 8'd21, 8'd22, 8'd26, 8'd27, 8'd28}};
        vecs[1]  = '{3'd2, {8'd15, 8'd16, 8'd17, 8'd21, 8'd22, 8'd23, 8'd27, 8'd28, 8'd29}};
        vecs[2]  = '{3'd2, {8'd15, 8'd16, 8'd17, 8'd21, 8'd22, 8'd23, 8'd27, 8'd28, 8'd29}};
        vecs[3]  = '{3'd6, w_org};
        vecs[4]  = '{3'd4, w_org};
        vecs[5]  = '{3'd3, w_org};
        vecs[6]  = '{3'd7, {8'd2, 8'd1, 8'd0, 8'd8, 8'd7, 8'd6, 8'd14, 8'd13, 8'd12}};
        vecs[7]  = '{3'd0, {8'd2, 8'd1, 8'd0, 8'd8, 8'd7, 8'd6, 8'd14, 8'd13, 8'd12}};
        vecs[8]  = '{3'd7, w_org};
        vecs[9]  = '{3'd5, {8'd6, 8'd7, 8'd8, 8'd12, 8'd13, 8'd14, 8'd18, 8'd19, 8'd20}};
        vecs[10] = '{3'd2, w_last};
        vecs[11] = '{3'd7, {8'd9, 8'd8, 8'd7, 8'd15, 8'd14, 8'd13, 8'd21, 8'd20, 8'd19}};
        vecs[12] = '{3'd7, w_last};

        repeat (3) @(negedge clk);
        check("rst_dataout", {24'd0, dataout}, 32'd0);
        check("rst_valid", {31'd0, output_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 13; v++) run_cmd(vecs[v].cmd, vecs[v].exp, 1'b0);

        // commands presented while busy must be dropped, not queued
        run_cmd(3'd0, w_last, 1'b1);
        run_cmd(3'd0, w_last, 1'b0);

        // reset after the 4th output pixel
        cmd       = 3'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_valid", {31'd0, output_valid}, 32'd1);
        check("pre_rst_pixel4", {24'd0, dataout}, 32'd13);
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, output_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_dataout", {24'd0, dataout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, output_valid | busy}, 32'd0);
        end
        run_cmd(3'd0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
